// File: rtl/axi_err_slv.sv
// axi_err_slv: AXI4 terminating responder. Every AW/W burst is answered with
// one B and every AR burst with len+1 R beats, all carrying a fixed error
// response. No memory is touched. Read and write sides are independent FSMs.
//
// Write FSM
//   state  | meaning
//   W_RST  | just out of reset, all write outputs low
//   W_IDLE | aw_ready high, waiting for an address
//   W_DATA | w_ready high, draining beats until w_last
//   W_RESP | b_valid high, holding the error response until b_ready
//
// Read FSM
//   state  | meaning
//   R_RST  | just out of reset, all read outputs low
//   R_IDLE | ar_ready high, waiting for an address
//   R_DATA | r_valid high, issuing beats 0..len with fixed data

module axi_err_slv #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 1,
    parameter logic [1:0]  RESP       = 2'b11,
    parameter logic [31:0] RESP_DATA  = 32'hCA11AB1E
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // write address channel
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    input  logic                    aw_lock,
    input  logic [3:0]              aw_cache,
    input  logic [2:0]              aw_prot,
    input  logic [3:0]              aw_qos,
    input  logic [3:0]              aw_region,
    input  logic [5:0]              aw_atop,
    input  logic [USER_WIDTH-1:0]   aw_user,
    // write data channel
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    input  logic [USER_WIDTH-1:0]   w_user,
    // write response channel
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [ID_WIDTH-1:0]     b_id,
    output logic [1:0]              b_resp,
    output logic [USER_WIDTH-1:0]   b_user,
    // read address channel
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [ID_WIDTH-1:0]     ar_id,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]              ar_len,
    input  logic [2:0]              ar_size,
    input  logic [1:0]              ar_burst,
    input  logic                    ar_lock,
    input  logic [3:0]              ar_cache,
    input  logic [2:0]              ar_prot,
    input  logic [3:0]              ar_qos,
    input  logic [3:0]              ar_region,
    input  logic [USER_WIDTH-1:0]   ar_user,
    // read data channel
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_WIDTH-1:0]     r_id,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp,
    output logic                    r_last,
    output logic [USER_WIDTH-1:0]   r_user
);

    localparam logic [1:0] W_RST  = 2'd0;
    localparam logic [1:0] W_IDLE = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_RST  = 2'd0;
    localparam logic [1:0] R_IDLE = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // Fixed read pattern, zero-extended or truncated to the bus width.
    localparam logic [DATA_WIDTH-1:0] RDATA = DATA_WIDTH'(RESP_DATA);

    logic [1:0]          w_state;
    logic [1:0]          w_state_nxt;
    logic [ID_WIDTH-1:0] w_id_q;

    logic [1:0]          r_state;
    logic [1:0]          r_state_nxt;
    logic [ID_WIDTH-1:0] r_id_q;
    logic [7:0]          r_len_q;
    logic [7:0]          r_cnt;

    // Address, attribute, data and user fields have no effect on the response.
    logic unused_inputs;
    assign unused_inputs = ^{aw_addr, aw_len, aw_size, aw_burst, aw_lock,
                             aw_cache, aw_prot, aw_qos, aw_region, aw_atop,
                             aw_user, w_data, w_strb, w_user,
                             ar_addr, ar_size, ar_burst, ar_lock, ar_cache,
                             ar_prot, ar_qos, ar_region, ar_user};

    // Write-side outputs, decoded from registered state only.
    assign aw_ready = (w_state == W_IDLE);
    assign w_ready  = (w_state == W_DATA);
    assign b_valid  = (w_state == W_RESP);
    assign b_id     = w_id_q;
    assign b_resp   = b_valid ? RESP : 2'b00;
    assign b_user   = '0;

    // Read-side outputs, decoded from registered state only.
    assign ar_ready = (r_state == R_IDLE);
    assign r_valid  = (r_state == R_DATA);
    assign r_id     = r_id_q;
    assign r_data   = r_valid ? RDATA : '0;
    assign r_resp   = r_valid ? RESP : 2'b00;
    assign r_last   = r_valid && (r_cnt == r_len_q);
    assign r_user   = '0;

    // Write FSM next-state; termination is on w_last alone, aw_len is not counted.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_RST:   w_state_nxt = W_IDLE;
            W_IDLE:  if (aw_valid) w_state_nxt = W_DATA;
            W_DATA:  if (w_valid && w_last) w_state_nxt = W_RESP;
            W_RESP:  if (b_ready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_RST;
        endcase
    end

    // Write state and captured AW id.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state <= W_RST;
            w_id_q  <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_valid && aw_ready) begin
                w_id_q <= aw_id;
            end
        end
    end

    // Read FSM next-state; the burst ends on the handshake of the r_last beat.
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_RST:   r_state_nxt = R_IDLE;
            R_IDLE:  if (ar_valid) r_state_nxt = R_DATA;
            R_DATA:  if (r_ready && r_last) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_RST;
        endcase
    end

    // Read state, captured AR id/len and beat counter. The counter holds on
    // the last beat so len=255 finishes with cnt=255 instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= R_RST;
            r_id_q  <= '0;
            r_len_q <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_valid && ar_ready) begin
                r_id_q  <= ar_id;
                r_len_q <= ar_len;
                r_cnt   <= '0;
            end else if (r_valid && r_ready && !r_last) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
